// File: rtl/demux8_buf_pkg.sv
// ============================================================================
// Module      : demux8_buf_pkg
// Description : Constants shared with the datapath select muxes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux8_buf_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int NCH       = 8;
  localparam int SELW      = 3;

  typedef logic [SELW-1:0] sel_t;
  typedef logic [NCH-1:0]  chmask_t;

  function automatic chmask_t sel_onehot(input sel_t sel);
    sel_onehot = chmask_t'(1) << sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux8_buf_chan_fifo.sv
// ============================================================================
// Module      : chan_fifo
// Description : Single-clock FIFO, one per demux channel; head is storage-driven.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chan_fifo #(
  parameter int width = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             empty
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [width-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wptr_q, wptr_d;
  logic [PTRW-1:0]  rptr_q, rptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rptr_q];

  // Guard here too so a misbehaving parent can never corrupt the count.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/demux8_buf.sv
// ============================================================================
// Module      : demux8_buf
// Description : Buffered 1-to-8 demultiplexer with a FIFO per destination.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux8_buf
  import demux8_buf_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      in_sel,
  input  logic [width-1:0]     in_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*width-1:0] out_data,
  output logic                 busy
);

  chmask_t full_w;
  chmask_t empty_w;
  chmask_t push_w;
  chmask_t pop_w;

  // in_ready looks only at the targeted channel's registered full flag,
  // so other channels' backpressure never stalls the producer.
  assign in_ready  = !full_w[in_sel];
  assign push_w    = (in_valid && in_ready) ? sel_onehot(in_sel) : '0;
  assign out_valid = ~empty_w;
  assign pop_w     = out_valid & out_ready;
  assign busy      = |out_valid;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    chan_fifo #(
      .width (width),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_w[k]),
      .din   (in_data),
      .full  (full_w[k]),
      .pop   (pop_w[k]),
      .dout  (out_data[k*width +: width]),
      .empty (empty_w[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_demux8_buf.sv
// ============================================================================
// Module      : tb_demux8_buf
// Description : Directed self-checking bench for demux8_buf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux8_buf;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_sel;
  logic [31:0]  in_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [255:0] out_data;
  logic         busy;

  int checks;
  int passed;

  demux8_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    in_data   = '0;
    out_ready = 8'h00;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 8'h00) $display("FAIL reset_out_valid: got %h want 00", out_valid);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else passed++;
    for (int k = 0; k < 8; k++) begin
      in_sel = 3'(k);
      #1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready sel=%0d: got %b want 1", k, in_ready);
      else passed++;
    end
  endtask

  task automatic test_routing();
    out_ready = 8'h00;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_sel   = 3'(k);
      in_data  = 32'hA0 + 32'(k);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'hFF) $display("FAIL route_out_valid: got %h want ff", out_valid);
    else passed++;
    checks++;
    if (busy !== 1'b1) $display("FAIL route_busy: got %b want 1", busy);
    else passed++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_data[k*32 +: 32] !== 32'hA0 + 32'(k))
        $display("FAIL route_data ch%0d: got %h want %h", k, out_data[k*32 +: 32], 32'hA0 + 32'(k));
      else passed++;
    end
    out_ready = 8'hFF;
    step();
    out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'h00 || busy !== 1'b0)
      $display("FAIL route_drain: got valid=%h busy=%b want 00/0", out_valid, busy);
    else passed++;
  endtask

  task automatic test_full();
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_sel    = 3'd5;
    for (int i = 1; i <= 2; i++) begin
      in_data = 32'h5000_0000 + 32'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL full_accept%0d: got in_ready=%b want 1", i, in_ready);
      else passed++;
      step();
    end
    in_data = 32'h5000_0003;
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL full_block: got in_ready=%b want 0", in_ready);
    else passed++;
    step();
    in_valid = 1'b0;
    in_sel   = 3'd2;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL full_other_sel: got in_ready=%b want 1", in_ready);
    else passed++;
    // Pop and attempted push on the full channel in the same cycle.
    in_valid  = 1'b1;
    in_sel    = 3'd5;
    out_ready = 8'h20;
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL full_pop_same_cycle: got in_ready=%b want 0", in_ready);
    else passed++;
    step();
    in_valid  = 1'b0;
    out_ready = 8'h00;
    checks++;
    if (out_valid[5] !== 1'b1 || out_data[5*32 +: 32] !== 32'h5000_0002)
      $display("FAIL full_head_adv: got v=%b d=%h want 1/50000002", out_valid[5], out_data[5*32 +: 32]);
    else passed++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL full_ready_back: got in_ready=%b want 1", in_ready);
    else passed++;
    out_ready = 8'h20;
    step();
    out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'h00) $display("FAIL full_no_third: got out_valid=%h want 00", out_valid);
    else passed++;
  endtask

  task automatic test_streaming();
    out_ready = 8'h08;
    in_sel    = 3'd3;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h0000_0300 + 32'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL stream_ready i=%0d: got %b want 1", i, in_ready);
      else passed++;
      step();
      checks++;
      if (out_valid !== 8'h08 || out_data[3*32 +: 32] !== 32'h0000_0300 + 32'(i))
        $display("FAIL stream_head i=%0d: got v=%h d=%h want 08/%h", i, out_valid,
                 out_data[3*32 +: 32], 32'h0000_0300 + 32'(i));
      else passed++;
    end
    in_valid = 1'b0;
    step();
    out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'h00) $display("FAIL stream_drain: got %h want 00", out_valid);
    else passed++;
  endtask

  task automatic test_independence();
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_sel    = 3'd1;
    in_data   = 32'h11;
    step();
    in_data = 32'h12;
    step();
    out_ready = 8'h81;
    for (int i = 0; i < 10; i++) begin
      in_sel  = (i % 2 == 0) ? 3'd0 : 3'd7;
      in_data = 32'hC000 + 32'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL indep_ready i=%0d: got %b want 1", i, in_ready);
      else passed++;
      step();
      checks++;
      if (out_data[32*int'(in_sel) +: 32] !== 32'hC000 + 32'(i))
        $display("FAIL indep_head i=%0d: got %h want %h", i, out_data[32*int'(in_sel) +: 32],
                 32'hC000 + 32'(i));
      else passed++;
    end
    in_valid = 1'b0;
    step();
    out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'h02 || out_data[32 +: 32] !== 32'h11)
      $display("FAIL indep_ch1_head: got v=%h d=%h want 02/11", out_valid, out_data[32 +: 32]);
    else passed++;
    out_ready = 8'h02;
    step();
    checks++;
    if (out_valid !== 8'h02 || out_data[32 +: 32] !== 32'h12)
      $display("FAIL indep_ch1_second: got v=%h d=%h want 02/12", out_valid, out_data[32 +: 32]);
    else passed++;
    step();
    out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'h00) $display("FAIL indep_ch1_drain: got %h want 00", out_valid);
    else passed++;
  endtask

  task automatic test_midreset();
    out_ready = 8'h00;
    for (int k = 0; k < 8; k += 2) begin
      in_valid = 1'b1;
      in_sel   = 3'(k);
      in_data  = 32'hD0 + 32'(k);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'h55) $display("FAIL mrst_pre: got %h want 55", out_valid);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 8'h00 || busy !== 1'b0)
      $display("FAIL mrst_async: got v=%h busy=%b want 00/0", out_valid, busy);
    else passed++;
    step();
    step();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_sel   = 3'd4;
    in_data  = 32'hF4;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'h10 || out_data[4*32 +: 32] !== 32'hF4)
      $display("FAIL mrst_fresh: got v=%h d=%h want 10/f4", out_valid, out_data[4*32 +: 32]);
    else passed++;
    out_ready = 8'h10;
    step();
    out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'h00) $display("FAIL mrst_no_stale: got %h want 00", out_valid);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_routing();
    test_full();
    test_streaming();
    test_independence();
    test_midreset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
